sub_bytes_sequencer: RTL and testbench
======================================

# sub_bytes_sequencer

Sequential AES SubBytes engine. It accepts a 128-bit state over a valid/ready handshake and substitutes its 16 bytes one at a time. Each byte's GF(2^8) inverse is computed by square-and-multiply (a^254), time-sharing a single GF multiplier-with-reduction, followed by the AES affine transform. It sits between the round-key adder and ShiftRows in the iterative cipher core, trading latency for area against a combinational S-box.

## Interface
- NBYTES, 16: bytes per state; state width is 8*NBYTES.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept a state.
- in_state  input  8*NBYTES  state to substitute; byte 0 = bits [8*NBYTES-1 -: 8] (FIPS-197 order).
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  consumer accepts out_state.
- out_state  output  8*NBYTES  substituted state, same byte order.
- busy  output  1  high in LOAD/MUL/STORE.
- inv  input  1  select InvSubBytes; present only with SUB_BYTES_SEQ_INV_EN.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1; on in_valid, latch in_state into the work register, set byte index idx=0, go to LOAD.
  - LOAD: base=byte[idx]; r=base; step=0; go to MUL.
  - MUL: 13 cycles, one multiplier use per cycle. Steps 0..11 alternate r=r*r (even step) and r=r*base (odd step). Step 12 is r=r*r. Result is r=base^254; 0 maps to 0. Then go to STORE.
  - STORE: byte[idx]=affine(r). If idx==NBYTES-1, go to DONE; otherwise idx++ and go to LOAD.
  - DONE: out_valid=1, out_state=work register. On out_ready, go to IDLE.
- Multiplier: carry-less 8x8 product (15 bits), reduced modulo 0x11B to 8 bits.
- Forward affine: b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, indices mod 8, c=0x63.
- in_ready is low outside IDLE. New input is ignored while busy, and there is no overlap of blocks.
- in_valid and in_ready both high in IDLE: accepted that edge. in_state is not re-sampled afterwards.
- DONE holds out_state stable until out_ready; backpressure is unlimited.
- Reset (any state, including mid-byte): FSM→IDLE, idx=0, work register=0.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_state=0.
- Per byte: 15 cycles (LOAD 1 + MUL 13 + STORE 1).
- Accept edge to out_valid high: NBYTES*15 cycles (240 at default).
- out_valid and out_ready in the same cycle: in_ready=1 the next cycle. The earliest next acceptance is one cycle after the output handshake.
- Multiplier path (product + reduction) is a single-cycle combinational path between r registers.

## Configuration
- SUB_BYTES_SEQ_INV_EN defined:
  - adds the inv port, sampled with in_state at acceptance and held for the block.
  - When inv=1, LOAD applies the inverse affine base = (a_(i+2) ^ a_(i+5) ^ a_(i+7)) ^ 0x05 before exponentiation, and STORE writes r without the affine.
  - Latency is unchanged.
- Undefined: no inv port; forward SubBytes only.

## Structure
- Package aes_sbox_pkg:
  - GF_POLY=9'h11B, AFFINE_C=8'h63, INV_AFFINE_C=8'h05, MUL_STEPS=13.
  - FSM state enum (IDLE, LOAD, MUL, STORE, DONE).
  - Affine and inverse-affine functions.
- One sub-module: gf256_mul (combinational, a, b → reduced product), instantiated once and muxed between r*r and r*base.

## Test plan
- Reset, then a single byte check with NBYTES=1: 0x00→0x63, 0x01→0x7c, 0x53→0xed, 0xff→0x16; each lands exactly 15 cycles after acceptance.
- FIPS-197 round-1 state 193de3bea0f4e22b9ac68d2ae9f84808 → d42711aee0bf98f1b8b45de51e415230, with out_valid at cycle 240.
- Backpressure: hold out_ready=0 for 50 cycles → out_valid and out_state stable, in_ready=0. Pulse out_ready → in_ready=1 the next cycle.
- Back-to-back: in_valid held high with two states; the second is accepted only after the first output handshake, and both results are correct.
- Assert rst at cycle 100 of a block → outputs return to reset values immediately. A subsequent block produces correct results.
- With SUB_BYTES_SEQ_INV_EN: inv=1 on d42711aee0bf98f1b8b45de51e415230 → 193de3bea0f4e22b9ac68d2ae9f84808; byte 0x63→0x00.

Source files
------------

// File: rtl/aes_sbox_pkg.sv
// +--------------------------------------------------------------------------+
// | aes_sbox_pkg: GF(2^8) constants, FSM encoding and AES affine transforms. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package aes_sbox_pkg;

  localparam logic [8:0]  GF_POLY      = 9'h11B;
  localparam logic [7:0]  AFFINE_C     = 8'h63;
  localparam logic [7:0]  INV_AFFINE_C = 8'h05;
  localparam int unsigned MUL_STEPS    = 13;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Right-rotations give bit i of the result as b[(i+k) mod 8].
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]}
             ^ {b[6:0], b[7]} ^ AFFINE_C;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ INV_AFFINE_C;
  endfunction

endpackage : aes_sbox_pkg

`default_nettype wire

// File: rtl/sub_bytes_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | sub_bytes_sequencer_if: state in/out handshakes (inv with SUB_BYTES_SEQ_INV_EN). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sub_bytes_sequencer_if #(
  parameter int unsigned NBYTES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_state;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_state;
  logic                  busy;
`ifdef SUB_BYTES_SEQ_INV_EN
  logic                  inv;

  modport master (
    output in_valid, in_state, out_ready, inv,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready, inv,
    output in_ready, out_valid, out_state, busy
  );
`else
  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );
`endif
endinterface : sub_bytes_sequencer_if

`default_nettype wire

// File: rtl/gf256_mul.sv
// +--------------------------------------------------------------------------+
// | gf256_mul: combinational carry-less 8x8 multiply reduced modulo 0x11B.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module gf256_mul
  import aes_sbox_pkg::*;
(
  input  wire logic [7:0] a_i,
  input  wire logic [7:0] b_i,
  output logic      [7:0] p_o
);

  logic [14:0] w_prod;

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) w_prod = w_prod ^ ({7'b0, a_i} << i);
    end
    // Fold the high terms down from the top so each step clears exactly one bit.
    for (int i = 14; i >= 8; i--) begin
      if (w_prod[i]) w_prod = w_prod ^ ({6'b0, GF_POLY} << (i - 8));
    end
    p_o = w_prod[7:0];
  end

endmodule : gf256_mul

`default_nettype wire

// File: rtl/sub_bytes_sequencer.sv
// +--------------------------------------------------------------------------+
// | sub_bytes_sequencer: byte-serial SubBytes via a^254 on one GF multiplier;|
// | InvSubBytes added by SUB_BYTES_SEQ_INV_EN.                 Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module sub_bytes_sequencer
  import aes_sbox_pkg::*;
#(
  parameter int unsigned NBYTES = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  sub_bytes_sequencer_if.slave bus
);

  localparam int unsigned      W        = 8 * NBYTES;
  localparam int unsigned      IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [3:0]       LAST_STEP = 4'(MUL_STEPS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     work_q, work_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       base_q, base_d;
  logic [7:0]       r_q, r_d;
  logic [3:0]       step_q, step_d;

  logic [7:0]       w_cur_byte;
  logic [7:0]       w_load_byte;
  logic [7:0]       w_store_byte;
  logic [7:0]       w_mul_b;
  logic [7:0]       w_mul_p;
  logic             w_inv;

`ifdef SUB_BYTES_SEQ_INV_EN
  logic inv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (state_q == IDLE && bus.in_valid) begin
      inv_q <= bus.inv;
    end
  end

  assign w_inv = inv_q;
`else
  assign w_inv = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = LOAD;
      LOAD:    state_d = MUL;
      MUL:     if (step_q == LAST_STEP) state_d = STORE;
      STORE:   state_d = (idx_q == LAST_IDX) ? DONE : LOAD;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q == LOAD) || (state_q == MUL) || (state_q == STORE);
    bus.out_state = work_q;
  end

  // Byte 0 lives in the MSBs of the work register.
  always_comb begin
    w_cur_byte = 8'h00;
    for (int j = 0; j < NBYTES; j++) begin
      if (idx_q == IDX_W'(j)) w_cur_byte = work_q[W-1-8*j -: 8];
    end
  end

  assign w_load_byte  = w_inv ? inv_affine(w_cur_byte) : w_cur_byte;
  assign w_store_byte = w_inv ? r_q : affine(r_q);

  // Even steps square, odd steps multiply by base: the chain ends at base^254.
  assign w_mul_b = step_q[0] ? base_q : r_q;

  gf256_mul u_mul (
    .a_i (r_q),
    .b_i (w_mul_b),
    .p_o (w_mul_p)
  );

  always_comb begin
    work_d = work_q;
    idx_d  = idx_q;
    base_d = base_q;
    r_d    = r_q;
    step_d = step_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.in_state;
          idx_d  = '0;
        end
      end
      LOAD: begin
        base_d = w_load_byte;
        r_d    = w_load_byte;
        step_d = '0;
      end
      MUL: begin
        r_d    = w_mul_p;
        step_d = step_q + 4'd1;
      end
      STORE: begin
        for (int j = 0; j < NBYTES; j++) begin
          if (idx_q == IDX_W'(j)) work_d[W-1-8*j -: 8] = w_store_byte;
        end
        if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      idx_q  <= '0;
      base_q <= '0;
      r_q    <= '0;
      step_q <= '0;
    end else begin
      work_q <= work_d;
      idx_q  <= idx_d;
      base_q <= base_d;
      r_q    <= r_d;
      step_q <= step_d;
    end
  end

endmodule : sub_bytes_sequencer

`default_nettype wire

// File: tb/tb_sub_bytes_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_sub_bytes_sequencer: random and FIPS-197 checks against a table model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sub_bytes_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

`ifdef SUB_BYTES_SEQ_INV_EN
  logic tb_inv = 1'b0;
`endif

  always #5 clk = ~clk;

  sub_bytes_sequencer_if #(.NBYTES(16)) bus16 ();
  sub_bytes_sequencer_if #(.NBYTES(1))  bus1 ();

  sub_bytes_sequencer #(.NBYTES(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  sub_bytes_sequencer #(.NBYTES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (ref_mul(a, 8'(c)) == 8'h01) return 8'(c);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_aff(input logic [7:0] b);
    logic [7:0] c, o;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      o[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return o;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] st, input logic iv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = iv ? isbox_t[st[127-8*i -: 8]] : sbox_t[st[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send16(input logic [127:0] st, output logic [127:0] res, output int lat);
    int guard;
    guard = 0;
    while (bus16.in_ready !== 1'b1 && guard < 1000) begin @(posedge clk); #1; guard++; end
    bus16.in_valid = 1'b1;
    bus16.in_state = st;
`ifdef SUB_BYTES_SEQ_INV_EN
    bus16.inv = tb_inv;
`endif
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus16.in_state = ~st;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
    res = bus16.out_state;
  endtask

  task automatic release16();
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b, output logic [7:0] res, output int lat);
    int guard;
    guard = 0;
    while (bus1.in_ready !== 1'b1 && guard < 1000) begin @(posedge clk); #1; guard++; end
    bus1.in_valid = 1'b1;
    bus1.in_state = b;
`ifdef SUB_BYTES_SEQ_INV_EN
    bus1.inv = tb_inv;
`endif
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus1.in_state = ~b;
    lat = 0;
    while (bus1.out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    res = bus1.out_state;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({bus16.in_ready, bus16.out_valid, bus16.busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_ctrl16: got rdy/vld/busy=%b required 100",
               {bus16.in_ready, bus16.out_valid, bus16.busy});
    end
    tests_run++;
    if (bus16.out_state !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_state16: got %h required 0", bus16.out_state);
    end
    tests_run++;
    if ({bus1.in_ready, bus1.out_valid, bus1.busy, bus1.out_state} !== {3'b100, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_dut1: got rdy/vld/busy=%b state=%h required 100/00",
               {bus1.in_ready, bus1.out_valid, bus1.busy}, bus1.out_state);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] vin [4];
    logic [7:0] vexp [4];
    logic [7:0] b, e, res;
    int         lat;
    vin  = '{8'h00, 8'h01, 8'h53, 8'hff};
    vexp = '{8'h63, 8'h7c, 8'hed, 8'h16};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin b = vin[i]; e = vexp[i]; end
      else begin b = 8'($urandom); e = sbox_t[b]; end
      send1(b, res, lat);
      tests_run++;
      if (res !== e) begin
        tests_failed++;
        $display("FAIL byte_%02h: got %02h required %02h", b, res, e);
      end
      tests_run++;
      if (lat != 15) begin
        tests_failed++;
        $display("FAIL byte_latency_%02h: got %0d required 15", b, lat);
      end
    end
  endtask

  task automatic test_fips();
    logic [127:0] res;
    int           lat;
    send16(128'h193de3bea0f4e22b9ac68d2ae9f84808, res, lat);
    tests_run++;
    if (res !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
      tests_failed++;
      $display("FAIL fips_result: got %h required d42711aee0bf98f1b8b45de51e415230", res);
    end
    tests_run++;
    if (lat != 240) begin
      tests_failed++;
      $display("FAIL fips_latency: got %0d required 240", lat);
    end
    release16();
  endtask

  task automatic test_random();
    logic [127:0] st, res;
    int           lat;
    for (int i = 0; i < 4; i++) begin
      st = rand_state();
      send16(st, res, lat);
      tests_run++;
      if (res !== ref_sub(st, 1'b0) || lat != 240) begin
        tests_failed++;
        $display("FAIL random_%0d: got %h lat %0d required %h lat 240",
                 i, res, lat, ref_sub(st, 1'b0));
      end
      release16();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] st, exp_v, res;
    int           lat;
    st    = rand_state();
    exp_v = ref_sub(st, 1'b0);
    send16(st, res, lat);
    tests_run++;
    if (res !== exp_v) begin
      tests_failed++;
      $display("FAIL bp_result: got %h required %h", res, exp_v);
    end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 || bus16.out_state !== exp_v) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b state=%h required 1/0/%h",
                 i, bus16.out_valid, bus16.in_ready, bus16.out_state, exp_v);
      end
    end
    release16();
    tests_run++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: got rdy=%b vld=%b required 1/0", bus16.in_ready, bus16.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, res;
    int           lat;
    a = rand_state();
    b = rand_state();
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    bus16.in_state  = a;
    @(posedge clk); #1;
    bus16.in_state = b;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
    tests_run++;
    if (bus16.out_state !== ref_sub(a, 1'b0) || lat != 240) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h lat %0d required %h lat 240",
               bus16.out_state, lat, ref_sub(a, 1'b0));
    end
    tests_run++;
    if (bus16.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_no_early_accept: got in_ready=%b required 0", bus16.in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle_gap: got rdy=%b vld=%b required 1/0", bus16.in_ready, bus16.out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus16.busy !== 1'b1 || bus16.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second_accept: got busy=%b rdy=%b required 1/0", bus16.busy, bus16.in_ready);
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 2000) begin @(posedge clk); #1; lat++; end
    res = bus16.out_state;
    tests_run++;
    if (res !== ref_sub(b, 1'b0) || lat != 240) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h lat %0d required %h lat 240", res, lat, ref_sub(b, 1'b0));
    end
    release16();
  endtask

  task automatic test_reset_mid();
    logic [127:0] st, res;
    int           lat;
    bus16.in_valid = 1'b1;
    bus16.in_state = rand_state();
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    repeat (99) @(posedge clk);
    #3;
    tests_run++;
    if (bus16.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_busy_before: got %b required 1", bus16.busy);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus16.in_ready, bus16.out_valid, bus16.busy} !== 3'b100 || bus16.out_state !== 128'h0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got rdy/vld/busy=%b state=%h required 100/0",
               {bus16.in_ready, bus16.out_valid, bus16.busy}, bus16.out_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    st = rand_state();
    send16(st, res, lat);
    tests_run++;
    if (res !== ref_sub(st, 1'b0) || lat != 240) begin
      tests_failed++;
      $display("FAIL midrst_after: got %h lat %0d required %h lat 240", res, lat, ref_sub(st, 1'b0));
    end
    release16();
  endtask

`ifdef SUB_BYTES_SEQ_INV_EN
  task automatic test_inverse();
    logic [127:0] st, res;
    logic [7:0]   r1;
    int           lat;
    tb_inv = 1'b1;
    send16(128'hd42711aee0bf98f1b8b45de51e415230, res, lat);
    tests_run++;
    if (res !== 128'h193de3bea0f4e22b9ac68d2ae9f84808 || lat != 240) begin
      tests_failed++;
      $display("FAIL inv_fips: got %h lat %0d required 193de3bea0f4e22b9ac68d2ae9f84808 lat 240",
               res, lat);
    end
    release16();
    st = rand_state();
    send16(st, res, lat);
    tests_run++;
    if (res !== ref_sub(st, 1'b1)) begin
      tests_failed++;
      $display("FAIL inv_random: got %h required %h", res, ref_sub(st, 1'b1));
    end
    release16();
    send1(8'h63, r1, lat);
    tests_run++;
    if (r1 !== 8'h00 || lat != 15) begin
      tests_failed++;
      $display("FAIL inv_byte_63: got %02h lat %0d required 00 lat 15", r1, lat);
    end
    tb_inv = 1'b0;
    bus16.inv = 1'b0;
    st = rand_state();
    send16(st, res, lat);
    tests_run++;
    if (res !== ref_sub(st, 1'b0)) begin
      tests_failed++;
      $display("FAIL inv_back_to_fwd: got %h required %h", res, ref_sub(st, 1'b0));
    end
    release16();
  endtask
`endif

  initial begin
    rst             = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_state  = '0;
    bus16.out_ready = 1'b0;
    bus1.in_valid   = 1'b0;
    bus1.in_state   = '0;
    bus1.out_ready  = 1'b0;
`ifdef SUB_BYTES_SEQ_INV_EN
    bus16.inv = 1'b0;
    bus1.inv  = 1'b0;
`endif
    for (int x = 0; x < 256; x++) begin
      sbox_t[x]            = ref_aff(ref_inv(8'(x)));
      isbox_t[sbox_t[x]]   = 8'(x);
    end

    test_reset();
    test_single_byte();
    test_fips();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef SUB_BYTES_SEQ_INV_EN
    test_inverse();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule : tb_sub_bytes_sequencer

`default_nettype wire
